// File: rtl/sram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : sram_burst_reader
// Purpose  : Fetches one frame from the pixel SRAM as consecutive bursts and
//            serializes each burst into a one-pixel-per-cycle valid/ready
//            stream. The SRAM's registered read_data doubles as the prefetch
//            buffer, so bursts stream back-to-back without bubbles.
// Revision : 1.0 - initial release
// ============================================================================
module sram_burst_reader #(
  parameter int PIXEL_W      = 24,
  parameter int BURST        = 64,
  parameter int ADDR_W       = 24,
  parameter int FRAME_PIXELS = 208896
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  output logic                       sram_read_enable,
  output logic [ADDR_W-1:0]          sram_address,
  input  logic [BURST*PIXEL_W-1:0]   sram_read_data,
  output logic [PIXEL_W-1:0]         pix_data,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic                       pix_sof,
  output logic                       pix_eof,
  output logic                       busy,
  output logic                       done
);

  localparam int c_NUM_BURSTS = FRAME_PIXELS / BURST;
  localparam int c_CNT_W      = (c_NUM_BURSTS > 1) ? $clog2(c_NUM_BURSTS) : 1;
  localparam int c_IDX_W      = $clog2(BURST);

  localparam logic [c_CNT_W-1:0] c_LAST_BURST  = c_CNT_W'(c_NUM_BURSTS - 1);
  localparam logic [c_CNT_W:0]   c_TOTAL_READS = (c_CNT_W + 1)'(c_NUM_BURSTS);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX    = c_IDX_W'(BURST - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE     = c_IDX_W'(1);
  localparam logic [c_CNT_W-1:0] c_BURST_ONE   = c_CNT_W'(1);
  localparam logic [c_CNT_W:0]   c_READ_ONE    = (c_CNT_W + 1)'(1);
  localparam logic [ADDR_W-1:0]  c_ADDR_STEP   = ADDR_W'(BURST);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;

  logic [BURST*PIXEL_W-1:0]   r_buf;        // burst currently being serialized
  logic                       r_buf_valid;  // r_buf holds pixels not yet sent
  logic [c_IDX_W-1:0]         r_idx;        // pixel index within r_buf
  logic [c_CNT_W-1:0]         r_burst;      // which burst of the frame r_buf is
  logic [c_CNT_W:0]           r_rd_cnt;     // reads issued this frame
  logic [ADDR_W-1:0]          r_next_addr;  // address of the next read to issue
  logic                       r_rd_d1;      // read pulse delayed: SRAM data valid now
  logic                       r_pf_valid;   // sram_read_data holds the next burst

  logic w_xfer;
  logic w_last_idx;
  logic w_last_burst;
  logic w_more_reads;
  logic w_accept;
  logic w_load;
  logic w_issue;
  logic w_finish;
  logic w_drain;

  assign w_xfer       = r_buf_valid & pix_ready;
  assign w_last_idx   = (r_idx == c_LAST_IDX);
  assign w_last_burst = (r_burst == c_LAST_BURST);
  assign w_more_reads = (r_rd_cnt < c_TOTAL_READS);

  assign pix_valid = r_buf_valid;
  assign pix_data  = r_buf_valid ? r_buf[r_idx*PIXEL_W +: PIXEL_W] : '0;
  assign pix_sof   = r_buf_valid & (r_burst == '0) & (r_idx == '0);
  assign pix_eof   = r_buf_valid & w_last_burst & w_last_idx;
  assign busy      = (r_state != S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and per-cycle control strobes for the datapath.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    w_issue      = 1'b0;
    w_finish     = 1'b0;
    w_drain      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        // First burst arrives the cycle after the SRAM samples the pulse.
        if (r_rd_d1) begin
          w_load       = 1'b1;
          w_issue      = w_more_reads;
          w_state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        if (r_buf_valid) begin
          if (w_xfer && w_last_idx) begin
            if (w_last_burst) begin
              w_finish     = 1'b1;
              w_state_next = S_IDLE;
            end else if (r_pf_valid) begin
              w_load  = 1'b1;
              w_issue = w_more_reads;
            end else begin
              w_drain = 1'b1;
            end
          end
        end else if (r_pf_valid) begin
          // Recovering from a late prefetch: reload as soon as it lands.
          w_load  = 1'b1;
          w_issue = w_more_reads;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Read issue, buffer load, pixel index and prefetch tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      sram_read_enable <= 1'b0;
      sram_address     <= '0;
      done             <= 1'b0;
      r_buf            <= '0;
      r_buf_valid      <= 1'b0;
      r_idx            <= '0;
      r_burst          <= '0;
      r_rd_cnt         <= '0;
      r_next_addr      <= '0;
      r_rd_d1          <= 1'b0;
      r_pf_valid       <= 1'b0;
    end else begin
      r_rd_d1          <= sram_read_enable;
      sram_read_enable <= w_accept | w_issue;
      done             <= w_finish;

      if (w_accept) begin
        sram_address <= base_addr;
        r_next_addr  <= base_addr + c_ADDR_STEP;
        r_rd_cnt     <= c_READ_ONE;
        r_burst      <= '0;
        r_idx        <= '0;
        r_buf_valid  <= 1'b0;
        r_pf_valid   <= 1'b0;
      end

      if (w_issue) begin
        sram_address <= r_next_addr;
        r_next_addr  <= r_next_addr + c_ADDR_STEP;
        r_rd_cnt     <= r_rd_cnt + c_READ_ONE;
      end

      // Prefetch data becomes usable one cycle after its read pulse.
      if (r_rd_d1 && (r_state == S_STREAM)) begin
        r_pf_valid <= 1'b1;
      end

      if (w_load) begin
        r_buf       <= sram_read_data;
        r_idx       <= '0;
        r_buf_valid <= 1'b1;
        r_pf_valid  <= 1'b0;
        if (r_state == S_STREAM) begin
          r_burst <= r_burst + c_BURST_ONE;
        end
      end else if (w_drain || w_finish) begin
        r_idx       <= '0;
        r_buf_valid <= 1'b0;
      end else if (w_xfer) begin
        r_idx <= r_idx + c_IDX_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_burst_reader
// Purpose  : Self-checking bench for sram_burst_reader with a 256-pixel frame
//            and an SRAM model whose pixel value equals its address.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_burst_reader;

  localparam int PW = 24;
  localparam int BW = 64;
  localparam int AW = 24;
  localparam int FP = 256;
  localparam int NB = FP / BW;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic             sram_read_enable;
  logic [AW-1:0]    sram_address;
  logic [BW*PW-1:0] sram_read_data = '0;
  logic [PW-1:0]    pix_data;
  logic             pix_valid;
  logic             pix_ready = 1'b0;
  logic             pix_sof;
  logic             pix_eof;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [PW-1:0] exp_q[$];
  logic [AW-1:0] rd_addr_q[$];
  int            frame_xfers = 0;
  int            done_cnt = 0;
  int            first_xfer_cyc = 0;
  int            last_xfer_cyc = 0;
  int            done_cyc = 0;
  int            last_rd_cyc = 0;
  int            start_cyc = 0;
  logic          prev_stall = 1'b0;
  logic [PW-1:0] prev_data = '0;
  logic          prev_sof = 1'b0;
  logic          prev_eof = 1'b0;
  logic [PW-1:0] mon_exp;

  sram_burst_reader #(
    .PIXEL_W      (PW),
    .BURST        (BW),
    .ADDR_W       (AW),
    .FRAME_PIXELS (FP)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .base_addr        (base_addr),
    .sram_read_enable (sram_read_enable),
    .sram_address     (sram_address),
    .sram_read_data   (sram_read_data),
    .pix_data         (pix_data),
    .pix_valid        (pix_valid),
    .pix_ready        (pix_ready),
    .pix_sof          (pix_sof),
    .pix_eof          (pix_eof),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  // Cycle counter for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: registered read, pixel value = pixel address.
  always @(posedge clk) begin
    if (sram_read_enable) begin
      for (int i = 0; i < BW; i++) begin
        sram_read_data[i*PW +: PW] <= PW'(sram_address + AW'(i));
      end
    end
  end

  // Output monitor: scoreboard pop on transfer, stall stability, read spacing.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (sram_read_enable) begin
        if (rd_addr_q.size() >= 2) begin
          n_checks++;
          if (cyc - last_rd_cyc < BW) begin
            n_fail++;
            $display("FAIL read_spacing: gap %0d cycles, required >= %0d", cyc - last_rd_cyc, BW);
          end
        end
        rd_addr_q.push_back(sram_address);
        last_rd_cyc = cyc;
      end
      if (prev_stall) begin
        n_checks++;
        if (pix_valid !== 1'b1 || pix_data !== prev_data || pix_sof !== prev_sof || pix_eof !== prev_eof) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%b data=%h sof=%b eof=%b, required valid=1 data=%h sof=%b eof=%b",
                   pix_valid, pix_data, pix_sof, pix_eof, prev_data, prev_sof, prev_eof);
        end
      end
      if (pix_valid && pix_ready) begin
        if (frame_xfers == 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pix_extra: got pixel %h, required no pixel", pix_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (pix_data !== mon_exp) begin
            n_fail++;
            $display("FAIL pix_data[%0d]: got %h, required %h", frame_xfers, pix_data, mon_exp);
          end
        end
        n_checks++;
        if (pix_sof !== ((frame_xfers == 0) ? 1'b1 : 1'b0)) begin
          n_fail++;
          $display("FAIL pix_sof[%0d]: got %b, required %b", frame_xfers, pix_sof, frame_xfers == 0);
        end
        n_checks++;
        if (pix_eof !== ((frame_xfers == FP - 1) ? 1'b1 : 1'b0)) begin
          n_fail++;
          $display("FAIL pix_eof[%0d]: got %b, required %b", frame_xfers, pix_eof, frame_xfers == FP - 1);
        end
        frame_xfers++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_data  = pix_data;
      prev_sof   = pix_sof;
      prev_eof   = pix_eof;
    end
  end

  task automatic reset_stats();
    exp_q.delete();
    rd_addr_q.delete();
    frame_xfers = 0;
    done_cnt    = 0;
  endtask

  // Pulse start for one cycle and push the expected frame into the scoreboard.
  task automatic do_start(input logic [AW-1:0] base);
    @(posedge clk);
    #1;
    base_addr = base;
    start     = 1'b1;
    start_cyc = cyc;
    for (int i = 0; i < FP; i++) exp_q.push_back(PW'(base + AW'(i)));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Drive pix_ready each cycle until done is seen or the budget expires.
  task automatic wait_done(input int pct, input int budget, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(posedge clk);
      #1;
      pix_ready = (pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < pct);
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic wait_xfers(input int n, input int budget, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      #1;
      if (frame_xfers >= n) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({sram_read_enable, pix_valid, pix_sof, pix_eof, busy, done} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ren/valid/sof/eof/busy/done=%b, required 000000",
               {sram_read_enable, pix_valid, pix_sof, pix_eof, busy, done});
    end
    n_checks++;
    if (pix_data !== '0 || sram_address !== '0) begin
      n_fail++;
      $display("FAIL reset_data: pix_data=%h sram_address=%h, required 0 0", pix_data, sram_address);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_reads(input string name, input logic [AW-1:0] base);
    n_checks++;
    if (rd_addr_q.size() != NB) begin
      n_fail++;
      $display("FAIL %s_read_count: got %0d, required %0d", name, rd_addr_q.size(), NB);
    end else begin
      for (int i = 0; i < NB; i++) begin
        n_checks++;
        if (rd_addr_q[i] !== AW'(base + AW'(i * BW))) begin
          n_fail++;
          $display("FAIL %s_read_addr[%0d]: got %h, required %h", name, i, rd_addr_q[i], AW'(base + AW'(i * BW)));
        end
      end
    end
  endtask

  task automatic test_basic();
    bit seen;
    reset_stats();
    pix_ready = 1'b1;
    do_start('0);
    @(negedge clk);  // C+1
    n_checks++;
    if (busy !== 1'b1 || sram_read_enable !== 1'b1 || sram_address !== '0 || pix_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_c1: busy=%b ren=%b addr=%h valid=%b, required 1 1 000000 0",
               busy, sram_read_enable, sram_address, pix_valid);
    end
    @(negedge clk);  // C+2
    n_checks++;
    if (pix_valid !== 1'b0 || sram_read_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_c2: valid=%b ren=%b, required 0 0", pix_valid, sram_read_enable);
    end
    @(negedge clk);  // C+3
    n_checks++;
    if (pix_valid !== 1'b1 || pix_data !== '0 || pix_sof !== 1'b1 ||
        sram_read_enable !== 1'b1 || sram_address !== AW'(BW)) begin
      n_fail++;
      $display("FAIL basic_c3: valid=%b data=%h sof=%b ren=%b addr=%h, required 1 000000 1 1 %h",
               pix_valid, pix_data, pix_sof, sram_read_enable, sram_address, AW'(BW));
    end
    wait_done(100, 1000, seen);
    #1;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL basic_timeout: done not seen, required within 1000 cycles");
    end
    n_checks++;
    if (frame_xfers != FP || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_count: got %0d pixels (%0d left), required %0d (0 left)", frame_xfers, exp_q.size(), FP);
    end
    n_checks++;
    if (first_xfer_cyc - start_cyc != 3 || last_xfer_cyc - first_xfer_cyc != FP - 1) begin
      n_fail++;
      $display("FAIL basic_timing: latency %0d span %0d, required 3 %0d",
               first_xfer_cyc - start_cyc, last_xfer_cyc - first_xfer_cyc, FP - 1);
    end
    n_checks++;
    if (done_cyc != last_xfer_cyc + 1 || done_cnt != 1 || busy !== 1'b0 || pix_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done_cyc=%0d cnt=%0d busy=%b valid=%b, required %0d 1 0 0",
               done_cyc, done_cnt, busy, pix_valid, last_xfer_cyc + 1);
    end
    check_reads("basic", '0);
  endtask

  task automatic test_backpressure();
    bit seen;
    reset_stats();
    pix_ready = 1'b0;
    do_start('0);
    wait_done(30, 5000, seen);
    #1;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL bp_timeout: done not seen, required within 5000 cycles");
    end
    n_checks++;
    if (frame_xfers != FP || exp_q.size() != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL bp_count: pixels=%0d left=%0d done=%0d, required %0d 0 1", frame_xfers, exp_q.size(), done_cnt, FP);
    end
    check_reads("bp", '0);
  endtask

  task automatic test_wrap();
    bit seen;
    reset_stats();
    pix_ready = 1'b1;
    do_start(24'hFFFFC0);
    wait_done(100, 1000, seen);
    #1;
    n_checks++;
    if (!seen || frame_xfers != FP || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_frame: seen=%b pixels=%0d left=%0d, required 1 %0d 0", seen, frame_xfers, exp_q.size(), FP);
    end
    check_reads("wrap", 24'hFFFFC0);
  endtask

  task automatic test_start_ignored();
    bit seen;
    reset_stats();
    pix_ready = 1'b1;
    do_start(24'h000100);
    wait_xfers(10, 100, seen);
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL ign_progress: %0d pixels, required >= 10", frame_xfers);
    end
    @(posedge clk);
    #1;
    base_addr = 24'h000555;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(100, 1000, seen);
    repeat (6) @(negedge clk);
    #1;
    n_checks++;
    if (!seen || frame_xfers != FP || exp_q.size() != 0 || done_cnt != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_frame: seen=%b pixels=%0d left=%0d done=%0d busy=%b, required 1 %0d 0 1 0",
               seen, frame_xfers, exp_q.size(), done_cnt, busy, FP);
    end
    check_reads("ign", 24'h000100);
  endtask

  task automatic test_reset_midstream();
    bit seen;
    reset_stats();
    pix_ready = 1'b1;
    do_start('0);
    wait_xfers(100, 300, seen);
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rst_progress: %0d pixels, required >= 100", frame_xfers);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({sram_read_enable, pix_valid, pix_sof, pix_eof, busy, done} !== 6'b0 || pix_data !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: ren/valid/sof/eof/busy/done=%b data=%h, required 000000 000000",
               {sram_read_enable, pix_valid, pix_sof, pix_eof, busy, done}, pix_data);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    reset_stats();
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (rd_addr_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_quiet: reads=%0d busy=%b, required 0 0", rd_addr_q.size(), busy);
    end
    do_start('0);
    wait_done(100, 1000, seen);
    #1;
    n_checks++;
    if (!seen || frame_xfers != FP || exp_q.size() != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL rst_restart: seen=%b pixels=%0d left=%0d done=%0d, required 1 %0d 0 1",
               seen, frame_xfers, exp_q.size(), done_cnt, FP);
    end
    check_reads("rst", '0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_start_ignored();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_burst_reader.md
# sram_burst_reader

Read-side client of the on-chip pixel SRAM (64 × 24-bit pixels per access). It fetches one frame as consecutive 64-pixel bursts starting at a latched base address. Each burst is serialized into a one-pixel-per-cycle valid/ready stream toward scan-out. The SRAM's registered `read_data` serves as the prefetch buffer, so bursts stream back-to-back with no bubbles. The block never drives the SRAM write port; the rasterizer owns it.

## Interface
- `PIXEL_W`, 24, bits per pixel (RGB888)
- `BURST`, 64, pixels per SRAM access; must be ≥ 4
- `ADDR_W`, 24, SRAM address width (pixel units)
- `FRAME_PIXELS`, 208896, pixels per frame; must be a multiple of `BURST`

- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: begin frame; sampled only in IDLE.
- `base_addr` in ADDR_W: first pixel address; latched when `start` is accepted.
- `sram_read_enable` out 1: registered; one-cycle pulse per burst.
- `sram_address` out ADDR_W: registered; burst start address, valid while `sram_read_enable`=1.
- `sram_read_data` in BURST*PIXEL_W: SRAM output; valid the cycle after SRAM samples `sram_read_enable`, held until the next read.
- `pix_data` out PIXEL_W: current pixel.
- `pix_valid` out 1: `pix_data` valid.
- `pix_ready` in 1: consumer accepts; transfer = `pix_valid & pix_ready` at rising edge.
- `pix_sof` out 1: qualifies the first pixel of the frame.
- `pix_eof` out 1: qualifies the last pixel of the frame.
- `busy` out 1: high from start acceptance until the last pixel transfers.
- `done` out 1: one-cycle pulse, cycle after last transfer.

## Operation
- States: IDLE, FETCH, STREAM.
- IDLE: `busy`=0. When `start`=1:
  - latch `base_addr`;
  - next cycle `sram_read_enable`=1 with `sram_address`=base;
  - burst counter = 0; go to FETCH.
- FETCH: waits for the first burst. Loads `sram_read_data` into the internal shift buffer 2 cycles after the read pulse, clears pixel index, then goes to STREAM.
  - If more bursts remain, issues the prefetch read (address + `BURST`) in the cycle after the load.
- STREAM:
  - `pix_data` = buffer slice [PIXEL_W*i+PIXEL_W-1 : PIXEL_W*i] for i = 0..BURST-1, lowest address first.
  - Index advances only on a transfer.
  - On the transfer of index BURST-1:
    - if bursts remain and prefetch data is present (`pf_valid`), reload the buffer from `sram_read_data` that same edge, then issue the next prefetch;
    - if this was the last burst, go to IDLE and pulse `done`.
  - If prefetch is not yet present, `pix_valid` drops until it arrives. This is unreachable for BURST ≥ 4 but must be implemented.
- `pf_valid` is set 2 cycles after a prefetch pulse and cleared on reload.
- Address arithmetic: burst k address = base + k*BURST, modulo 2^ADDR_W (wraps silently).
- Burst count = FRAME_PIXELS/BURST; counter width = clog2 of that.
- `pix_sof` = `pix_valid` & first burst & index 0.
- `pix_eof` = `pix_valid` & last burst & index BURST-1.
- `start` while not IDLE is ignored; it is not queued.
- Reset (any state): state IDLE; `sram_read_enable`, `sram_address`, `pix_data`, `pix_valid`, `pix_sof`, `pix_eof`, `busy`, `done`, `pf_valid`, counters all 0. SRAM data in flight is discarded.

## Timing
- `start` sampled high in cycle C (IDLE):
  - `busy`=1 and `sram_read_enable`=1 in C+1;
  - SRAM registers data at end of C+1; buffer loads at end of C+2;
  - `pix_valid`=1 in C+3 (3-cycle start-to-pixel latency);
  - first prefetch pulse in C+3.
- Under continuous `pix_ready`=1, exactly FRAME_PIXELS consecutive `pix_valid` cycles, with no gap at burst boundaries.
- `sram_read_enable` pulses exactly FRAME_PIXELS/BURST times per frame, each 1 cycle wide.
- Backpressure: while `pix_valid`=1 and `pix_ready`=0, `pix_data`, `pix_sof` and `pix_eof` hold stable. `pix_valid` does not depend combinationally on `pix_ready`.
- Last transfer at edge E: `pix_valid`=0, `busy`=0, `done`=1 in the cycle after E. A `start` in that cycle is accepted as in IDLE.

## Test plan
- Reset: assert `reset` mid-stream at pixel 100 → next cycle all outputs 0; no further `sram_read_enable`; `start` 2 cycles later begins a clean frame at index 0.
- Small frame, FRAME_PIXELS=256, base=0, `pix_ready`=1, SRAM model preloaded with pixel value = address:
  - read pulses at 0, 64, 128, 192;
  - `pix_valid` from C+3 for 256 consecutive cycles, `pix_data` 0..255;
  - `pix_sof` on pixel 0 only, `pix_eof` on pixel 255 only;
  - `done` the following cycle.
- Burst boundary: pixels 63→64 and 127→128 on adjacent cycles; `sram_read_enable` never pulses twice within 64 cycles.
- Backpressure, `pix_ready` pseudo-random at 30% → output sequence 0..255 exact; no loss, no duplicates; data stable during stalls; total read pulses = 4.
- Wrap: base=0xFFFFC0, 2 bursts → addresses 0xFFFFC0, then 0x000000; pixel order is preserved.
- `start` pulsed while busy at pixel 10 → ignored; exactly one frame, one `done`.
